// File: rtl/mole_tracker.sv
// Whack-a-mole tracker: lights requested LEDs for a level-dependent lifetime,
// scores hits against button edges and ends the game after too many misses.
//
// state | meaning
// IDLE  | after reset, waiting for start; requests and buttons ignored
// PLAY  | game running; LEDs light, expire and get hit
// OVER  | miss limit reached; LEDs dark, waiting for start
module mole_tracker #(
  parameter int LED_COUNT   = 18,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int LIFE0       = 30,
  parameter int LIFE1       = 15,
  parameter int LIFE2       = 8,
  parameter int MAX_MISSES  = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [1:0]                   level_i,
  input  logic                         led_request_i,
  input  logic [$clog2(LED_COUNT)-1:0] led_index_i,
  input  logic [LED_COUNT-1:0]         btn_i,
  output logic [LED_COUNT-1:0]         leds_o,
  output logic                         hit_pulse_o,
  output logic                         miss_pulse_o,
  output logic [15:0]                  score_o,
  output logic [7:0]                   misses_o,
  output logic                         game_over_o
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t                state_q;
  logic [PW-1:0]         presc_q;
  logic [LED_COUNT-1:0]  leds_q, leds_d, btn_q;
  logic [CW-1:0]         cnt_q [LED_COUNT];
  logic [CW-1:0]         cnt_d [LED_COUNT];
  logic [15:0]           score_q, score_d;
  logic [7:0]            misses_q, misses_d;
  logic                  hit_pulse_q, miss_pulse_q, game_over_q;

  logic                  play, tick, req_ok;
  logic [CW-1:0]         life_sel;
  logic [LED_COUNT-1:0]  edge_v, hit_v, wrong_v, expire_v, req_v;
  logic [7:0]            n_hit, n_miss;
  logic [16:0]           score_sum;
  logic [8:0]            miss_sum;

  always_comb begin
    play   = (state_q == PLAY);
    tick   = play && (presc_q == PW'(TICK_CYCLES - 1));
    req_ok = play && led_request_i && (32'(led_index_i) < LED_COUNT);
    case (level_i)
      2'b01:   life_sel = CW'(LIFE1);
      2'b10:   life_sel = CW'(LIFE2);
      default: life_sel = CW'(LIFE0);
    endcase
    // Edges are judged against the LED state before any same-cycle request.
    edge_v  = btn_i & ~btn_q & {LED_COUNT{play}};
    hit_v   = edge_v & leds_q;
    wrong_v = edge_v & ~leds_q;
    leds_d  = leds_q;
    for (int i = 0; i < LED_COUNT; i++) begin
      expire_v[i] = tick && leds_q[i] && (cnt_q[i] == CW'(1)) && !hit_v[i];
      req_v[i]    = req_ok && (32'(led_index_i) == i) && !leds_q[i];
      cnt_d[i]    = cnt_q[i];
      if (hit_v[i] || expire_v[i]) begin
        leds_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (req_v[i]) begin
        leds_d[i] = 1'b1;
        cnt_d[i]  = life_sel;
      end else if (tick && leds_q[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
    n_hit     = 8'($countones(hit_v));
    n_miss    = 8'($countones(expire_v)) + 8'($countones(wrong_v));
    score_sum = {1'b0, score_q} + 17'(n_hit);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    miss_sum  = {1'b0, misses_q} + {1'b0, n_miss};
    misses_d  = (miss_sum >= 9'(MAX_MISSES)) ? 8'(MAX_MISSES) : miss_sum[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      leds_q       <= '0;
      btn_q        <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
      for (int i = 0; i < LED_COUNT; i++) cnt_q[i] <= '0;
    end else begin
      btn_q        <= btn_i;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      case (state_q)
        PLAY: begin
          presc_q      <= tick ? '0 : presc_q + PW'(1);
          leds_q       <= leds_d;
          score_q      <= score_d;
          misses_q     <= misses_d;
          hit_pulse_q  <= |hit_v;
          miss_pulse_q <= |expire_v || |wrong_v;
          for (int i = 0; i < LED_COUNT; i++) cnt_q[i] <= cnt_d[i];
          if (misses_q == 8'(MAX_MISSES)) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
            presc_q     <= '0;
            leds_q      <= '0;
            for (int i = 0; i < LED_COUNT; i++) cnt_q[i] <= '0;
          end
        end
        default: begin
          presc_q <= '0;
          if (start_i) begin
            state_q     <= PLAY;
            game_over_q <= 1'b0;
            score_q     <= '0;
            misses_q    <= '0;
            leds_q      <= '0;
            for (int i = 0; i < LED_COUNT; i++) cnt_q[i] <= '0;
          end
        end
      endcase
    end
  end

  assign leds_o       = leds_q;
  assign hit_pulse_o  = hit_pulse_q;
  assign miss_pulse_o = miss_pulse_q;
  assign score_o      = score_q;
  assign misses_o     = misses_q;
  assign game_over_o  = game_over_q;

endmodule

// File: doc/mole_tracker.md
Name: mole_tracker

Overview:
- Consumer end of the LED request interface: accepts one-cycle led_request/led_index pulses from the random LED generator and lights the addressed LED for a level-dependent lifetime.
- Detects player button presses against lit LEDs and reports hits, misses and wrong presses.
- Keeps a saturating score and a miss count, and ends the game through a small state machine.
- Sits between the generator, the board LEDs/buttons and the score display.

Parameters:
LED_COUNT, 18, number of LEDs/buttons
TICK_CYCLES, 5_000_000, clk cycles per lifetime tick (0.1 s at 50 MHz)
LIFE0, 30, lifetime in ticks for level 2'b00 (and 2'b11)
LIFE1, 15, lifetime in ticks for level 2'b01
LIFE2, 8, lifetime in ticks for level 2'b10
MAX_MISSES, 10, miss count that ends the game

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; IDLE/OVER -> PLAY
level  in  2  difficulty; selects LIFEn
led_request  in  1  one-cycle pulse: light led_index
led_index  in  $clog2(LED_COUNT)  LED to light
btn  in  LED_COUNT  player buttons, already synchronised, active-high level
leds  out  LED_COUNT  lit-LED bitmap (registered)
hit_pulse  out  1  one cycle when at least one lit LED is pressed
miss_pulse  out  1  one cycle when at least one miss or wrong press occurs
score  out  16  hit count, saturates at 16'hFFFF
misses  out  8  miss count, saturates at MAX_MISSES
game_over  out  1  high while in OVER

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; leds=0; hit_pulse=0; miss_pulse=0; score=0; misses=0; game_over=0; tick prescaler=0; all lifetime counters=0; btn history=0.
- FSM states: IDLE, PLAY, OVER.
  - IDLE: requests and buttons are ignored. start -> PLAY.
  - PLAY -> OVER on the cycle misses becomes equal to MAX_MISSES.
  - OVER -> PLAY on start.
  - Any entry into PLAY clears score, misses, leds and all lifetime counters.
- game_over is registered and goes high the cycle after misses reaches MAX_MISSES. In OVER, leds=0 and requests/buttons are ignored.
- Tick: the prescaler counts 0..TICK_CYCLES-1 in PLAY only. The tick strobe is asserted on the wrap cycle. The prescaler is held at 0 outside PLAY.
- Request (PLAY, led_request=1, led_index<LED_COUNT, LED currently off):
  - leds[idx]=1 on the next cycle (1-cycle latency).
  - The LED's counter loads the LIFEn selected by level in the request cycle.
- Ignored requests:
  - Requests to an already-lit LED: no lifetime refresh.
  - Requests with led_index>=LED_COUNT.
- Expiry: on each tick, every lit LED's counter decrements. When the counter goes 1->0, the LED turns off next cycle and the event counts as a miss.
- Button edge: btn[i]=1 with the previous-cycle btn[i]=0.
  - Edge on a lit LED = hit: LED off next cycle, counter cleared.
  - Edge on an unlit LED = wrong press, which counts as a miss.
  - A held button generates no further events.
- Per cycle:
  - score += popcount(hits), saturating.
  - misses += popcount(expiries) + popcount(wrong presses), saturating at MAX_MISSES.
  - hit_pulse and miss_pulse are registered, so they assert the cycle after the event.
- Simultaneous events on the same LED in the same cycle:
  - Hit and expiry: the hit wins and no miss is counted.
  - Hit and request: the hit wins and the request is ignored (the LED goes off).
  - Request and edge on an unlit LED: counted as a wrong press (the edge is evaluated against the pre-request state), and the LED still lights.
- start during PLAY is ignored.
- Reset asserted mid-game returns all outputs to their reset values immediately.

Test Plan:
- Bench parameters: TICK_CYCLES=4, LIFE0=3, LIFE1=2, LIFE2=1, MAX_MISSES=3.
- Reset then start; request idx 5 at level 00 -> leds=0x00020 one cycle later; no press -> LED off and miss_pulse after 3 ticks (~12 cycles), misses=1.
- Request idx 2; press btn[2] (rising edge) 3 cycles later -> leds[2]=0 and hit_pulse high the next cycle, score=1; holding btn[2] produces no second hit.
- Press btn[7] with no LED lit -> miss_pulse, misses=1; request idx 17 and idx 18 -> only leds[17] lights; idx 18 has no effect.
- Request idx 4; press btn[4] exactly on its expiry tick -> score=1, misses unchanged; re-request idx 4 while lit -> lifetime not refreshed (expires at the original time).
- Accumulate 3 misses -> game_over=1 one cycle after misses=3; leds=0; requests ignored; start -> game_over=0, score=0, misses=0.
- Lit LEDs at idx 0 and 1, press both in the same cycle -> score+=2, a single hit_pulse; assert rst low mid-game -> all outputs 0 immediately, state IDLE.
